serpent_sbox_inv_stage: RTL and testbench

Registered inverse-S-box and key-mix stage of the Serpent decryption datapath. Consumes the 128-bit output of the inverse linear transform, applies the bitsliced inverse S-box selected by the round index across all 32 columns, XORs the round subkey, and presents the result on a valid/ready interface. The result feeds the next round's inverse linear transform, or the output port after the final round.

---
 rtl/serpent_pkg.sv | 58 +++++
 rtl/serpent_sbox_inv_slice.sv | 12 +
 rtl/serpent_sbox_inv_stage.sv | 96 +++++++++
 tb/tb_serpent_sbox_inv_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// Shared Serpent constants: block geometry, inverse S-box tables and the
// bitslice column helpers used by both the forward and inverse S-box stages.
package serpent_pkg;

  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int NUM_ROUNDS = 32;
  localparam int ROUND_W    = $clog2(NUM_ROUNDS);

  localparam logic [3:0] INV_S0 [16] = '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC,
                                         4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2};
  localparam logic [3:0] INV_S1 [16] = '{4'h5, 4'h8, 4'h2, 4'hE, 4'hF, 4'h6, 4'hC, 4'h3,
                                         4'hB, 4'h4, 4'h7, 4'h9, 4'h1, 4'hD, 4'hA, 4'h0};
  localparam logic [3:0] INV_S2 [16] = '{4'hC, 4'h9, 4'hF, 4'h4, 4'hB, 4'hE, 4'h1, 4'h2,
                                         4'h0, 4'h3, 4'h6, 4'hD, 4'h5, 4'h8, 4'hA, 4'h7};
  localparam logic [3:0] INV_S3 [16] = '{4'h0, 4'h9, 4'hA, 4'h7, 4'hB, 4'hE, 4'h6, 4'hD,
                                         4'h3, 4'h5, 4'hC, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1};
  localparam logic [3:0] INV_S4 [16] = '{4'h5, 4'h0, 4'h8, 4'h3, 4'hA, 4'h9, 4'h7, 4'hE,
                                         4'h2, 4'hC, 4'hB, 4'h6, 4'h4, 4'hF, 4'hD, 4'h1};
  localparam logic [3:0] INV_S5 [16] = '{4'h8, 4'hF, 4'h2, 4'h9, 4'h4, 4'h1, 4'hD, 4'hE,
                                         4'hB, 4'h6, 4'h5, 4'h3, 4'h7, 4'hC, 4'hA, 4'h0};
  localparam logic [3:0] INV_S6 [16] = '{4'hF, 4'hA, 4'h1, 4'hD, 4'h5, 4'h3, 4'h6, 4'h0,
                                         4'h4, 4'h9, 4'hE, 4'h7, 4'h2, 4'hC, 4'h8, 4'hB};
  localparam logic [3:0] INV_S7 [16] = '{4'h3, 4'h0, 4'h6, 4'hD, 4'h9, 4'hE, 4'hF, 4'h8,
                                         4'h5, 4'hC, 4'hB, 4'h7, 4'hA, 4'h1, 4'h4, 4'h2};

  function automatic logic [3:0] inv_sbox(input logic [2:0] box, input logic [3:0] n);
    logic [3:0] result;
    case (box)
      3'd0:    result = INV_S0[n];
      3'd1:    result = INV_S1[n];
      3'd2:    result = INV_S2[n];
      3'd3:    result = INV_S3[n];
      3'd4:    result = INV_S4[n];
      3'd5:    result = INV_S5[n];
      3'd6:    result = INV_S6[n];
      default: result = INV_S7[n];
    endcase
    return result;
  endfunction

  // Column j is {X3[j],X2[j],X1[j],X0[j]}; X0 occupies the top word of the block.
  function automatic logic [3:0] get_column(input logic [BLOCK_W-1:0] blk, input int j);
    return {blk[j], blk[WORD_W+j], blk[2*WORD_W+j], blk[3*WORD_W+j]};
  endfunction

  function automatic logic [BLOCK_W-1:0] put_column(input logic [BLOCK_W-1:0] blk,
                                                    input int j, input logic [3:0] nib);
    logic [BLOCK_W-1:0] result;
    result              = blk;
    result[3*WORD_W+j]  = nib[0];
    result[2*WORD_W+j]  = nib[1];
    result[WORD_W+j]    = nib[2];
    result[j]           = nib[3];
    return result;
  endfunction

endpackage

// File: rtl/serpent_sbox_inv_slice.sv
// One bitslice column of the inverse S-box layer: 4-bit lookup in box 0..7.
module serpent_sbox_inv_slice
  import serpent_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic [2:0] box,
  output logic [3:0] result
);

  assign result = inv_sbox(box, nibble);

endmodule

// File: rtl/serpent_sbox_inv_stage.sv
// Registered inverse S-box + subkey XOR stage with valid/ready handshake.
// Optional one-entry skid buffer enabled by defining SERPENT_SBOX_INV_SKID_EN.
module serpent_sbox_inv_stage
  import serpent_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BLOCK_W-1:0] i_data,
  input  logic [ROUND_W-1:0] i_round,
  input  logic [BLOCK_W-1:0] i_subkey,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BLOCK_W-1:0] o_data,
  output logic [ROUND_W-1:0] o_round
);

  logic [WORD_W-1:0][3:0] col_out;
  logic [BLOCK_W-1:0]     sbox_out;
  logic [BLOCK_W-1:0]     next_data;
  logic                   in_xfer;
  logic                   out_xfer;

  for (genvar j = 0; j < WORD_W; j++) begin : g_col
    serpent_sbox_inv_slice u_slice (
      .nibble (get_column(i_data, j)),
      .box    (i_round[2:0]),
      .result (col_out[j])
    );
  end

  always_comb begin
    sbox_out = '0;
    for (int j = 0; j < WORD_W; j++) begin
      sbox_out = put_column(sbox_out, j, col_out[j]);
    end
  end

  assign next_data = sbox_out ^ i_subkey;
  assign in_xfer   = i_valid && o_ready;
  assign out_xfer  = o_valid && i_ready;

`ifdef SERPENT_SBOX_INV_SKID_EN
  logic               skid_empty;
  logic [BLOCK_W-1:0] skid_data;
  logic [ROUND_W-1:0] skid_round;

  assign o_ready = skid_empty;

  // When the output slot frees up, a waiting skid beat always wins over new input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_round    <= '0;
      skid_empty <= 1'b1;
      skid_data  <= '0;
      skid_round <= '0;
    end else if (out_xfer || !o_valid) begin
      if (!skid_empty) begin
        o_data     <= skid_data;
        o_round    <= skid_round;
        skid_empty <= 1'b1;
      end else if (in_xfer) begin
        o_data  <= next_data;
        o_round <= i_round;
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= next_data;
      skid_round <= i_round;
      skid_empty <= 1'b0;
    end
  end
`else
  assign o_ready = !o_valid || i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_round <= '0;
    end else if (in_xfer) begin
      o_data  <= next_data;
      o_round <= i_round;
      o_valid <= 1'b1;
    end else if (out_xfer) begin
      o_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_serpent_sbox_inv_stage.sv
// Directed self-checking bench for serpent_sbox_inv_stage; expected values come
// from hand-computed vectors and forward S-box round trips.
module tb_serpent_sbox_inv_stage;

`ifdef SERPENT_SBOX_INV_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int NB = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic [4:0]   i_round;
  logic [127:0] i_subkey;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;
  logic [4:0]   o_round;

  int checks   = 0;
  int failures = 0;

  logic [3:0]       fwd [8][16];
  logic [3:0]       inv0 [16];
  logic [127:0]     bd [32];
  logic [127:0]     bk [32];
  logic [127:0]     be [32];
  logic [4:0]       br [32];
  logic [31:0][3:0] cols;
  logic [31:0][3:0] rcols;
  logic             acc;
  int               sent;
  int               got;

  serpent_sbox_inv_stage dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_round  (i_round),
    .i_subkey (i_subkey),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_round  (o_round)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [127:0] pack_cols(input logic [31:0][3:0] c);
    logic [127:0] blk;
    blk = '0;
    for (int j = 0; j < 32; j++) begin
      blk[96+j] = c[j][0];
      blk[64+j] = c[j][1];
      blk[32+j] = c[j][2];
      blk[j]    = c[j][3];
    end
    return blk;
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] d, input logic [4:0] r, input logic [127:0] k);
    i_valid  = 1'b1;
    i_data   = d;
    i_round  = r;
    i_subkey = k;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Random expected result per column, input built through the forward S-box.
  task automatic makeBeat(input int idx, input logic [4:0] rnd);
    for (int j = 0; j < 32; j++) begin
      rcols[j] = 4'($urandom_range(15, 0));
      cols[j]  = fwd[rnd[2:0]][rcols[j]];
    end
    bk[idx] = {$urandom, $urandom, $urandom, $urandom};
    bd[idx] = pack_cols(cols);
    be[idx] = pack_cols(rcols) ^ bk[idx];
    br[idx] = rnd;
  endtask

  initial begin
    fwd[0] = '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC};
    fwd[1] = '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4};
    fwd[2] = '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2};
    fwd[3] = '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE};
    fwd[4] = '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD};
    fwd[5] = '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1};
    fwd[6] = '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0};
    fwd[7] = '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6};
    inv0   = '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2};

    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data   = '0;
    i_round  = '0;
    i_subkey = '0;
    #12;
    checkOutput("reset_out", {o_valid, o_round, o_data}, '0);
    i_rst_n = 1'b1;
    tick();
    checkOutput("reset_ready", o_ready, 1);

    // Zero state through InvS0, then the same through InvS0 via round 8 with an all-ones key
    i_ready = 1'b1;
    checkOutput("pre_xfer_valid", o_valid, 0);
    applyStimulus('0, 5'd0, '0);
    tick();
    checkOutput("zero_r0", {o_valid, o_round, o_data},
                {1'b1, 5'd0, 128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF});
    applyStimulus('0, 5'd8, {128{1'b1}});
    tick();
    i_valid = 1'b0;
    checkOutput("zero_r8_ones", {o_valid, o_round, o_data},
                {1'b1, 5'd8, 128'h00000000_FFFFFFFF_00000000_00000000});

    for (int j = 0; j < 32; j++) begin
      cols[j]  = (j < 16) ? 4'(j) : 4'h0;
      rcols[j] = (j < 16) ? inv0[j] : 4'hD;
    end
    applyStimulus(pack_cols(cols), 5'd0, '0);
    tick();
    i_valid = 1'b0;
    checkOutput("inv_s0_table", {o_valid, o_round, o_data}, {1'b1, 5'd0, pack_cols(rcols)});

    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 32; j++) begin
        cols[j]  = fwd[b][j % 16];
        rcols[j] = 4'(j % 16);
      end
      applyStimulus(pack_cols(cols), {2'(b), 3'(b)}, '0);
      tick();
      i_valid = 1'b0;
      checkOutput("box_round_trip", {o_valid, o_round, o_data},
                  {1'b1, 2'(b), 3'(b), pack_cols(rcols)});
    end
    tick();
    checkOutput("idle_after_boxes", o_valid, 0);

    for (int k = 0; k < 32; k++) makeBeat(k, 5'(k));
    for (int k = 0; k < 32; k++) begin
      applyStimulus(bd[k], br[k], bk[k]);
      tick();
      checkOutput("b2b_beat", {o_valid, o_round, o_data}, {1'b1, br[k], be[k]});
    end
    i_valid = 1'b0;
    tick();
    checkOutput("b2b_drained", o_valid, 0);

    // Stall five cycles, then release and drain in order
    for (int k = 0; k < NB; k++) makeBeat(k, 5'(20 + k));
    i_ready = 1'b0;
    sent = 0;
    got  = 0;
    applyStimulus(bd[0], br[0], bk[0]);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("stall_ready", o_ready, sent < CAP);
      acc = i_valid && o_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent < NB) applyStimulus(bd[sent], br[sent], bk[sent]);
        else i_valid = 1'b0;
      end
      checkOutput("stall_hold", {o_valid, o_round, o_data}, {1'b1, br[0], be[0]});
    end
    checkOutput("stall_accepted", sent, CAP);
    i_ready = 1'b1;
    for (int c = 0; c < 20 && got < NB; c++) begin
      #1;
      acc = i_valid && o_ready;
      if (o_valid) begin
        checkOutput("drain_beat", {o_round, o_data}, {br[got], be[got]});
        got++;
      end
      tick();
      if (acc) begin
        sent++;
        if (sent < NB) applyStimulus(bd[sent], br[sent], bk[sent]);
        else i_valid = 1'b0;
      end
    end
    checkOutput("drain_count", got, NB);
    #1;
    checkOutput("drain_empty", o_valid, 0);

    // Fill to capacity, then reset asynchronously between clock edges
    tick();
    i_ready = 1'b0;
    for (int c = 0; c < CAP; c++) begin
      applyStimulus(bd[c], br[c], bk[c]);
      tick();
    end
    i_valid = 1'b0;
    checkOutput("pre_reset_valid", {o_valid, o_ready}, {1'b1, CAP == 1 ? 1'b0 : 1'b0});
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out", {o_valid, o_round, o_data}, '0);
    checkOutput("async_reset_ready", o_ready, 1);
    #2;
    i_rst_n = 1'b1;
    tick();
    i_ready = 1'b1;
    applyStimulus('0, 5'd1, '0);
    tick();
    i_valid = 1'b0;
    checkOutput("post_reset_beat", {o_valid, o_round, o_data},
                {1'b1, 5'd1, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000});
    tick();
    checkOutput("post_reset_empty", o_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
